// File: rtl/eth_frame_tx_framer_if.sv
// eth_frame_tx_framer_if: 8-bit AXI-Stream byte channel.
// master drives data/valid/last/user, slave drives ready.
interface eth_frame_tx_framer_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/eth_frame_tx_framer.sv
// eth_frame_tx_framer: preamble/SFD insertion, zero pad, IFG.
// Define ETH_FRAMER_FCS_EN to append the CRC-32 FCS in this stage.
module eth_frame_tx_framer #(
  parameter int unsigned MIN_FRAME_LEN = 60,
  parameter int unsigned IFG_CYCLES    = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  eth_frame_tx_framer_if.slave  s_axis,
  eth_frame_tx_framer_if.master m_axis,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_PAY,
    S_PAD,
    S_FCS,
    S_IFG
  } state_t;

  localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME_LEN);
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nx;
  logic [7:0]  r_tdata;
  logic [7:0]  w_tdata_nx;
  logic        r_tvalid;
  logic        w_tvalid_nx;
  logic        r_tlast;
  logic        w_tlast_nx;
  logic        r_tuser;
  logic        w_tuser_nx;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nx;
  logic [15:0] w_cnt_inc;
  logic [2:0]  r_pre;
  logic [2:0]  w_pre_nx;
  logic [15:0] r_ifg;
  logic [15:0] w_ifg_nx;
  logic        r_err;
  logic        w_err_nx;
  logic        w_adv;
  logic        w_take;

`ifdef ETH_FRAMER_FCS_EN
  logic [31:0] r_crc;
  logic [31:0] w_crc_nx;
  logic [1:0]  r_fidx;
  logic [1:0]  w_fidx_nx;
  logic [31:0] w_fcs;

  function automatic logic [31:0] crc_upd(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] x;
    x = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      x = x[0] ? ((x >> 1) ^ 32'hEDB88320)
               : (x >> 1);
    end
    return x;
  endfunction

  // latched error forces a bad FCS so receivers drop the frame
  assign w_fcs = r_err ? r_crc : ~r_crc;
`endif

  assign w_adv     = !r_tvalid || m_axis.tready;
  assign w_take    = (r_state == S_PAY) && w_adv
                     && s_axis.tvalid;
  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt
                     : r_cnt + 16'd1;

  assign s_axis.tready = (r_state == S_PAY) && w_adv;
  assign m_axis.tdata  = r_tdata;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tlast  = r_tlast;
  assign m_axis.tuser  = r_tuser;
  assign busy          = (r_state != S_IDLE);

  always_comb begin
    w_state_nx  = r_state;
    w_tdata_nx  = r_tdata;
    w_tvalid_nx = r_tvalid;
    w_tlast_nx  = r_tlast;
    w_tuser_nx  = r_tuser;
    w_cnt_nx    = r_cnt;
    w_pre_nx    = r_pre;
    w_ifg_nx    = r_ifg;
    w_err_nx    = r_err;
`ifdef ETH_FRAMER_FCS_EN
    w_crc_nx    = r_crc;
    w_fidx_nx   = r_fidx;
`endif
    if (w_adv) begin
      w_tvalid_nx = 1'b0;
      w_tlast_nx  = 1'b0;
      w_tuser_nx  = 1'b0;
    end
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nx  = '0;
        w_pre_nx  = '0;
        w_ifg_nx  = '0;
        w_err_nx  = 1'b0;
`ifdef ETH_FRAMER_FCS_EN
        w_crc_nx  = 32'hFFFFFFFF;
        w_fidx_nx = '0;
`endif
        if (s_axis.tvalid && w_adv) begin
          w_tvalid_nx = 1'b1;
          w_tdata_nx  = 8'h55;
          w_pre_nx    = 3'd1;
          w_state_nx  = S_PRE;
        end
      end
      S_PRE: begin
        if (w_adv) begin
          w_tvalid_nx = 1'b1;
          w_tdata_nx  = 8'h55;
          w_pre_nx    = r_pre + 3'd1;
          if (r_pre == 3'd6) w_state_nx = S_SFD;
        end
      end
      S_SFD: begin
        if (w_adv) begin
          w_tvalid_nx = 1'b1;
          w_tdata_nx  = 8'hD5;
          w_state_nx  = S_PAY;
        end
      end
      S_PAY: begin
        if (w_take) begin
          w_tvalid_nx = 1'b1;
          w_tdata_nx  = s_axis.tdata;
          w_cnt_nx    = w_cnt_inc;
`ifdef ETH_FRAMER_FCS_EN
          w_crc_nx    = crc_upd(r_crc, s_axis.tdata);
`endif
          if (s_axis.tlast) begin
            w_err_nx = s_axis.tuser;
            if (w_cnt_inc < MIN_LEN) begin
              w_state_nx = S_PAD;
            end else begin
`ifdef ETH_FRAMER_FCS_EN
              w_state_nx = S_FCS;
`else
              w_tlast_nx = 1'b1;
              w_tuser_nx = s_axis.tuser;
              w_state_nx = S_IFG;
`endif
            end
          end
        end
      end
      S_PAD: begin
        if (w_adv) begin
          w_tvalid_nx = 1'b1;
          w_tdata_nx  = 8'h00;
          w_cnt_nx    = w_cnt_inc;
`ifdef ETH_FRAMER_FCS_EN
          w_crc_nx    = crc_upd(r_crc, 8'h00);
          if (w_cnt_inc >= MIN_LEN) w_state_nx = S_FCS;
`else
          if (w_cnt_inc >= MIN_LEN) begin
            w_tlast_nx = 1'b1;
            w_tuser_nx = r_err;
            w_state_nx = S_IFG;
          end
`endif
        end
      end
`ifdef ETH_FRAMER_FCS_EN
      S_FCS: begin
        if (w_adv) begin
          w_tvalid_nx = 1'b1;
          w_tdata_nx  = w_fcs[8*r_fidx +: 8];
          w_fidx_nx   = r_fidx + 2'd1;
          if (r_fidx == 2'd3) begin
            w_tlast_nx = 1'b1;
            w_tuser_nx = r_err;
            w_state_nx = S_IFG;
          end
        end
      end
`endif
      S_IFG: begin
        // gap is timed only once the final beat has drained
        if (!r_tvalid) begin
          w_ifg_nx = r_ifg + 16'd1;
          if (r_ifg == IFG_LAST) w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
      r_cnt    <= '0;
      r_pre    <= '0;
      r_ifg    <= '0;
      r_err    <= 1'b0;
`ifdef ETH_FRAMER_FCS_EN
      r_crc    <= 32'hFFFFFFFF;
      r_fidx   <= '0;
`endif
    end else begin
      r_state  <= w_state_nx;
      r_tdata  <= w_tdata_nx;
      r_tvalid <= w_tvalid_nx;
      r_tlast  <= w_tlast_nx;
      r_tuser  <= w_tuser_nx;
      r_cnt    <= w_cnt_nx;
      r_pre    <= w_pre_nx;
      r_ifg    <= w_ifg_nx;
      r_err    <= w_err_nx;
`ifdef ETH_FRAMER_FCS_EN
      r_crc    <= w_crc_nx;
      r_fidx   <= w_fidx_nx;
`endif
    end
  end

endmodule

// File: tb/tb_eth_frame_tx_framer.sv
// tb_eth_frame_tx_framer: frame-level model vs DUT wire stream.
// Build with ETH_FRAMER_FCS_EN to cover the FCS variant.
module tb_eth_frame_tx_framer;
  localparam int MIN = 60;
  localparam int IFG = 12;
`ifdef ETH_FRAMER_FCS_EN
  localparam int FCS_N = 4;
`else
  localparam int FCS_N = 0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  int checks   = 0;
  int failures = 0;

  beat_t      exp_q[$];
  logic [7:0] cap[$];
  logic [7:0] cap_last[$];
  int         bi          = 0;
  int         idle        = 0;
  bit         have_last   = 0;
  int         frames_done = 0;
  int         last_len    = 0;
  logic       last_user   = 1'b0;
  bit         prev_stall  = 0;
  beat_t      prev_b;
  bit         stall_en    = 0;

  eth_frame_tx_framer_if s_if();
  eth_frame_tx_framer_if m_if();

  eth_frame_tx_framer #(
    .MIN_FRAME_LEN(MIN),
    .IFG_CYCLES   (IFG)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .s_axis(s_if),
    .m_axis(m_if),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc_run(
    input logic [31:0] c0,
    input logic [7:0]  q[$]
  );
    logic [31:0] c;
    logic        b;
    c = c0;
    foreach (q[i]) begin
      for (int k = 0; k < 8; k++) begin
        b = c[0] ^ q[i][k];
        c = c >> 1;
        if (b) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  // wire image of one frame, straight from the framing rules
  task automatic model_frame(input logic [7:0] pl[$],
                             input logic u);
    logic [7:0]  f[$];
    beat_t       b[$];
    logic [31:0] fcs;
    f = pl;
    while (f.size() < MIN) f.push_back(8'h00);
    for (int i = 0; i < 7; i++)
      b.push_back('{8'h55, 1'b0, 1'b0});
    b.push_back('{8'hD5, 1'b0, 1'b0});
    foreach (f[i]) b.push_back('{f[i], 1'b0, 1'b0});
    if (FCS_N == 4) begin
      fcs = ~crc_run(32'hFFFFFFFF, f);
      if (u) fcs = ~fcs;
      for (int i = 0; i < 4; i++)
        b.push_back('{fcs[8*i +: 8], 1'b0, 1'b0});
    end
    b[b.size()-1].l = 1'b1;
    b[b.size()-1].u = u;
    foreach (b[i]) exp_q.push_back(b[i]);
  endtask

  task automatic drive_beat(input logic [7:0] d,
                            input logic l,
                            input logic u);
    bit ok = 0;
    int n  = 0;
    s_if.tdata  = d;
    s_if.tlast  = l;
    s_if.tuser  = u;
    s_if.tvalid = 1'b1;
    while (!ok && n < 2000) begin
      @(negedge clk);
      ok = s_if.tready;
      @(posedge clk);
      #1;
      n++;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL input_accept act=timeout exp=accepted");
    end
  endtask

  task automatic send_frame(input logic [7:0] pl[$],
                            input logic u,
                            input bit gaps,
                            input int abort_at);
    int last;
    last = pl.size() - 1;
    model_frame(pl, u);
    foreach (pl[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      if (abort_at >= 0 && i == abort_at) begin
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sready", 32'(s_if.tready), 32'd0);
        return;
      end
      drive_beat(pl[i], i == last, u && (i == last));
    end
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_done < target && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("frames_done", 32'(frames_done), 32'(target));
  endtask

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = stall_en ? 1'($urandom_range(0, 1))
                             : 1'b1;
    end
  end

  always @(negedge clk) begin
    beat_t      g;
    beat_t      e;
    logic [7:0] tail[$];
    g = '{m_if.tdata, m_if.tlast, m_if.tuser};
    if (reset) begin
      bi         = 0;
      idle       = 0;
      have_last  = 0;
      prev_stall = 0;
      cap.delete();
    end else begin
      if (prev_stall)
        chk("hold", 32'(g), 32'(prev_b));
      if (m_if.tvalid || s_if.tready)
        chk("busy_active", 32'(busy), 32'd1);
      if (m_if.tvalid && m_if.tready) begin
        if (bi == 0 && have_last)
          chk("ifg_gap", 32'(idle >= IFG), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat act=%h exp=none", g);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("beat%0d", bi), 32'(g), 32'(e));
        end
        cap.push_back(g.d);
        bi++;
        if (g.l) begin
          if (FCS_N == 4 && !g.u) begin
            tail.delete();
            for (int i = 8; i < cap.size(); i++)
              tail.push_back(cap[i]);
            chk("fcs_residue",
                crc_run(32'hFFFFFFFF, tail), 32'hDEBB20E3);
          end
          last_len  = bi;
          last_user = g.u;
          cap_last  = cap;
          cap.delete();
          bi        = 0;
          idle      = 0;
          have_last = 1;
          frames_done++;
        end
      end else if (!m_if.tvalid && have_last) begin
        idle++;
        if (idle <= IFG)
          chk("busy_ifg", 32'(busy), 32'd1);
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_b     = g;
    end
  end

  initial begin
    logic [7:0] pl[$];
    reset       = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = 8'h00;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_tlast", 32'(m_if.tlast), 32'd0);
    chk("rst_tuser", 32'(m_if.tuser), 32'd0);
    chk("rst_tdata", 32'(m_if.tdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sready", 32'(s_if.tready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
           8'h36, 8'h37, 8'h38, 8'h39};
    chk("model_crc", ~crc_run(32'hFFFFFFFF, pl),
        32'hCBF43926);

    // single-byte frame: 59 pad bytes
    pl = '{8'hAB};
    send_frame(pl, 1'b0, 1'b0, -1);
    wait_frames(1);
    chk("t1_len", 32'(last_len), 32'(68 + FCS_N));
    chk("t1_sfd", 32'(cap_last[7]), 32'hD5);
    chk("t1_byte", 32'(cap_last[8]), 32'hAB);
    chk("t1_pad", 32'(cap_last[67]), 32'h00);

    // 64 bytes: no padding
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'(i));
    send_frame(pl, 1'b0, 1'b0, -1);
    wait_frames(2);
    chk("t2_len", 32'(last_len), 32'(72 + FCS_N));
    chk("t2_last_pay", 32'(cap_last[71]), 32'h3F);

    // exactly minimum length with error flag
    pl.delete();
    for (int i = 0; i < 60; i++) pl.push_back(8'(i) ^ 8'h5A);
    send_frame(pl, 1'b1, 1'b0, -1);
    wait_frames(3);
    chk("t5_len", 32'(last_len), 32'(68 + FCS_N));
    chk("t5_user", 32'(last_user), 32'd1);

    // back-to-back with output stalls and input gaps
    stall_en = 1;
    pl.delete();
    for (int i = 0; i < 59; i++) pl.push_back(8'(3 * i + 1));
    send_frame(pl, 1'b0, 1'b1, -1);
    pl.delete();
    for (int i = 0; i < 61; i++) pl.push_back(8'(255 - i));
    send_frame(pl, 1'b1, 1'b1, -1);
    pl = '{8'hC3};
    send_frame(pl, 1'b0, 1'b1, -1);
    wait_frames(6);
    chk("t4_len", 32'(last_len), 32'(68 + FCS_N));
    stall_en = 0;

    // reset after 20 payload bytes, then a clean frame
    pl.delete();
    for (int i = 0; i < 40; i++) pl.push_back(8'(i + 100));
    send_frame(pl, 1'b0, 1'b0, 20);
    pl.delete();
    for (int i = 0; i < 10; i++) pl.push_back(8'(7 * i));
    send_frame(pl, 1'b0, 1'b0, -1);
    wait_frames(7);
    chk("t6_len", 32'(last_len), 32'(68 + FCS_N));
    chk("t6_pre", 32'(cap_last[0]), 32'h55);
    chk("t6_sfd", 32'(cap_last[7]), 32'hD5);

    repeat (30) @(posedge clk);
    chk("exp_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
